// File: rtl/nn_pkg.sv
// Shared constants and FSM state encoding for the classifier output stage.
package nn_pkg;

    localparam int unsigned DATA_WIDTH  = 16;
    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned IDX_WIDTH   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/argmax_select.sv
// Sequential argmax over one captured score vector: one compare per clock,
// result held until the consumer accepts it.
module argmax_select #(
    parameter int unsigned DATA_WIDTH  = nn_pkg::DATA_WIDTH,
    parameter int unsigned NUM_CLASSES = nn_pkg::NUM_CLASSES,
    parameter int unsigned IDX_WIDTH   = nn_pkg::IDX_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CLASSES*DATA_WIDTH-1:0] in_data,
    input  logic [NUM_CLASSES-1:0]            in_valid,
    output logic [IDX_WIDTH-1:0]              result_idx,
    output logic [DATA_WIDTH-1:0]             result_max,
    output logic                              result_valid,
    input  logic                              result_ready,
    output logic                              busy,
    output logic                              overrun
);

    import nn_pkg::state_t;
    import nn_pkg::ST_IDLE;
    import nn_pkg::ST_SCAN;
    import nn_pkg::ST_DONE;

    state_t                  state;
    state_t                  state_next;
    logic                    v_prev;
    logic [IDX_WIDTH-1:0]    cnt;
    logic [DATA_WIDTH-1:0]   vec [NUM_CLASSES];
    logic [DATA_WIDTH-1:0]   best_val;
    logic [IDX_WIDTH-1:0]    best_idx;

    logic                    rise;
    logic                    last;
    logic                    take;
    logic [DATA_WIDTH-1:0]   cur_score;
    logic [DATA_WIDTH-1:0]   scan_val;
    logic [IDX_WIDTH-1:0]    scan_idx;

    // Only neuron 0 carries the vector-valid strobe; the rest are don't-care.
    logic unused_valid_bits;
    assign unused_valid_bits = ^in_valid[NUM_CLASSES-1:1];

    assign busy = (state != ST_IDLE);

    // Compare step and next-state decode.
    always_comb begin
        rise       = in_valid[0] & ~v_prev;
        cur_score  = vec[cnt];
        take       = (cur_score > best_val);
        scan_val   = take ? cur_score : best_val;
        scan_idx   = take ? cnt : best_idx;
        last       = (cnt == IDX_WIDTH'(NUM_CLASSES - 1));
        state_next = state;
        case (state)
            ST_IDLE: if (rise)         state_next = ST_SCAN;
            ST_SCAN: if (last)         state_next = ST_DONE;
            ST_DONE: if (result_ready) state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            v_prev       <= 1'b0;
            cnt          <= '0;
            best_val     <= '0;
            best_idx     <= '0;
            result_valid <= 1'b0;
            result_idx   <= '0;
            result_max   <= '0;
            overrun      <= 1'b0;
        end else begin
            state   <= state_next;
            v_prev  <= in_valid[0];
            // Any new vector outside IDLE (including the accepting edge) is dropped.
            overrun <= rise && (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (rise) begin
                        for (int unsigned i = 0; i < NUM_CLASSES; i++) begin
                            vec[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                        best_val <= in_data[DATA_WIDTH-1:0];
                        best_idx <= '0;
                        cnt      <= IDX_WIDTH'(1);
                    end
                end
                ST_SCAN: begin
                    best_val <= scan_val;
                    best_idx <= scan_idx;
                    cnt      <= cnt + IDX_WIDTH'(1);
                    if (last) begin
                        result_valid <= 1'b1;
                        result_idx   <= scan_idx;
                        result_max   <= scan_val;
                    end
                end
                ST_DONE: begin
                    if (result_ready) result_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_argmax_select.sv
// Scoreboard bench for argmax_select: expected results queued at stimulus,
// popped when result_valid rises.
module tb_argmax_select;

    localparam int unsigned DW = 16;
    localparam int unsigned NC = 10;
    localparam int unsigned IW = 4;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [DW-1:0] mx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [NC*DW-1:0] in_data;
    logic [NC-1:0]    in_valid;
    logic [IW-1:0]    result_idx;
    logic [DW-1:0]    result_max;
    logic             result_valid;
    logic             result_ready;
    logic             busy;
    logic             overrun;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic valid_q = 1'b0;

    argmax_select dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .result_idx   (result_idx),
        .result_max   (result_max),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    // Pop and compare on every rising result_valid.
    always @(negedge clk) begin
        exp_t e;
        if (result_valid === 1'b1 && valid_q !== 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got idx=%0d max=%h, required no result", result_idx, result_max);
            end else begin
                e = sb.pop_front();
                if (result_idx !== e.idx || result_max !== e.mx) begin
                    errors++;
                    $display("FAIL result: got idx=%0d max=%h, required idx=%0d max=%h",
                             result_idx, result_max, e.idx, e.mx);
                end
            end
        end
        valid_q = result_valid;
    end

    function automatic exp_t model(input logic [NC*DW-1:0] v);
        exp_t r;
        r.idx = '0;
        r.mx  = v[DW-1:0];
        for (int i = 1; i < NC; i++) begin
            if (v[i*DW +: DW] > r.mx) begin
                r.mx  = v[i*DW +: DW];
                r.idx = IW'(i);
            end
        end
        return r;
    endfunction

    // Called at a negedge; returns one negedge after the capture edge.
    task automatic start_vector(input logic [NC*DW-1:0] v, input logic push);
        in_data = v;
        if (push) sb.push_back(model(v));
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
    endtask

    task automatic wait_result(output int k);
        k = 1;
        while (result_valid !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = '0; in_data = '0; result_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0 ||
            result_idx !== '0 || result_max !== '0) begin
            errors++;
            $display("FAIL reset: got valid=%b busy=%b ovr=%b idx=%0d max=%h, required all 0",
                     result_valid, busy, overrun, result_idx, result_max);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_vec(input string name, input logic [DW-1:0] s [NC]);
        logic [NC*DW-1:0] v;
        int k;
        for (int i = 0; i < NC; i++) v[i*DW +: DW] = s[i];
        start_vector(v, 1'b1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy_after_capture: got %b, required 1", name, busy);
        end
        wait_result(k);
        checks++;
        if (k !== 10) begin
            errors++;
            $display("FAIL %s latency: got %0d edges, required 9", name, k - 1);
        end
        accept();
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: got valid=%b busy=%b, required 0 0", name, result_valid, busy);
        end
    endtask

    task automatic test_hold_overrun();
        logic [DW-1:0] s [NC];
        logic [NC*DW-1:0] v;
        exp_t e;
        int k;
        s = '{16'd5, 16'd50, 16'd500, 16'd7, 16'd500, 16'd1, 16'd2, 16'd3, 16'd4, 16'd6};
        for (int i = 0; i < NC; i++) v[i*DW +: DW] = s[i];
        e = model(v);
        start_vector(v, 1'b1);
        wait_result(k);
        repeat (20) @(negedge clk);
        checks++;
        if (result_valid !== 1'b1 || result_idx !== e.idx || result_max !== e.mx) begin
            errors++;
            $display("FAIL hold: got valid=%b idx=%0d max=%h, required 1 %0d %h",
                     result_valid, result_idx, result_max, e.idx, e.mx);
        end
        in_data = {NC{16'hFFFF}};
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        checks++;
        if (overrun !== 1'b1) begin
            errors++;
            $display("FAIL overrun_pulse: got %b, required 1", overrun);
        end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0 || result_idx !== e.idx || result_max !== e.mx || result_valid !== 1'b1) begin
            errors++;
            $display("FAIL overrun_after: got ovr=%b idx=%0d max=%h valid=%b, required 0 %0d %h 1",
                     overrun, result_idx, result_max, result_valid, e.idx, e.mx);
        end
        accept();
        checks++;
        if (result_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_accept: got valid=%b, required 0", result_valid);
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_accept_collision();
        logic [NC*DW-1:0] v;
        int k;
        int busy_seen;
        for (int i = 0; i < NC; i++) v[i*DW +: DW] = DW'(i * 3);
        start_vector(v, 1'b1);
        wait_result(k);
        result_ready = 1'b1;
        in_data = '0;
        in_valid[0] = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL accept_collision: got valid=%b busy=%b ovr=%b, required 0 0 1",
                     result_valid, busy, overrun);
        end
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy === 1'b1) busy_seen++;
        end
        in_valid[0] = 1'b0;
        checks++;
        if (busy_seen !== 0) begin
            errors++;
            $display("FAIL level_no_retrigger: got %0d busy cycles, required 0", busy_seen);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        logic [NC*DW-1:0] v;
        for (int i = 0; i < NC; i++) v[i*DW +: DW] = DW'(100 - i);
        start_vector(v, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || result_valid !== 1'b0 || result_idx !== '0 ||
            result_max !== '0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_scan: got busy=%b valid=%b idx=%0d max=%h ovr=%b, required all 0",
                     busy, result_valid, result_idx, result_max, overrun);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (result_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_result: got valid=%b busy=%b, required 0 0", result_valid, busy);
        end
    endtask

    task automatic test_level_high();
        logic [NC*DW-1:0] v;
        int n_res;
        int k;
        for (int i = 0; i < NC; i++) v[i*DW +: DW] = DW'(i == 6 ? 900 : 10 + i);
        result_ready = 1'b1;
        in_data = v;
        sb.push_back(model(v));
        in_valid[0] = 1'b1;
        n_res = 0;
        repeat (50) begin
            @(negedge clk);
            if (result_valid === 1'b1) n_res++;
        end
        in_valid[0] = 1'b0;
        checks++;
        if (n_res !== 1) begin
            errors++;
            $display("FAIL level_high_results: got %0d, required 1", n_res);
        end
        @(negedge clk);
        v[3*DW +: DW] = 16'hABCD;
        start_vector(v, 1'b1);
        wait_result(k);
        checks++;
        if (k !== 10) begin
            errors++;
            $display("FAIL second_edge_latency: got %0d edges, required 9", k - 1);
        end
        @(negedge clk);
        result_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [NC*DW-1:0] v;
        int k;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < NC; i++) v[i*DW +: DW] = DW'($urandom_range(0, (n == 2) ? 3 : 65535));
            start_vector(v, 1'b1);
            wait_result(k);
            checks++;
            if (k !== 10) begin
                errors++;
                $display("FAIL b2b_latency[%0d]: got %0d edges, required 9", n, k - 1);
            end
            accept();
        end
    endtask

    initial begin
        logic [DW-1:0] s [NC];
        test_reset();
        s = '{16'd3, 16'd7, 16'd2, 16'd9, 16'd1, 16'd0, 16'd4, 16'd8, 16'd5, 16'd6};
        test_vec("test_a", s);
        s = '{default: 16'h0010};
        test_vec("test_b_tie", s);
        s = '{default: 16'h7FFF};
        s[9] = 16'hFFFF;
        test_vec("test_c_unsigned", s);
        test_hold_overrun();
        test_accept_collision();
        test_reset_mid_scan();
        test_level_high();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
